// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches an instruction, waits for the execution unit,
// then issues exactly one PC register strobe (replace / increment / add) per instruction.
module pc_sequencer #(
    parameter int                DATA_W        = 16,
    parameter logic [DATA_W-1:0] TRAP_VECTOR   = 16'hFFF0,
    parameter int unsigned       FETCH_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              exec_done,
    input  logic              jmp_valid,
    input  logic [DATA_W-1:0] jmp_target,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] br_offset,
    input  logic              halt,
    input  logic              resume,
    output logic              pc_replace,
    output logic              pc_increment,
    output logic              pc_add,
    output logic [DATA_W-1:0] pc_d,
    output logic              fault
);

    localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RESET_PC,
        S_FETCH,
        S_EXEC,
        S_UPDATE,
        S_HALTED,
        S_TRAP
    } state_t;

    state_t state_q, state_d;

    logic                     rst_done_q;
    logic [7:0]               cnt_q;
    logic [DATA_W-1:0]        ir_q;
    logic                     ir_valid_q;
    logic                     fault_q;
    logic                     jmp_q;
    logic                     br_q;
    logic                     halt_q;
    logic [DATA_W-1:0]        jmp_tgt_q;
    logic signed [DATA_W-1:0] br_off_q;

    logic ack_take;
    logic timeout;
    logic exec_take;

    // An ack in the final allowed cycle takes precedence over the timeout.
    assign ack_take  = (state_q == S_FETCH) && mem_ack;
    assign timeout   = (state_q == S_FETCH) && !mem_ack && (cnt_q == CNT_LAST);
    assign exec_take = (state_q == S_EXEC) && exec_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET_PC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        pc_replace   = 1'b0;
        pc_increment = 1'b0;
        pc_add       = 1'b0;
        pc_d         = '0;
        case (state_q)
            S_RESET_PC: begin
                // Held silent until one clock edge has passed after reset release.
                if (rst_done_q) begin
                    pc_replace = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (ack_take) begin
                    state_d = S_EXEC;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                if (exec_take) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (jmp_q) begin
                    pc_replace = 1'b1;
                    pc_d       = jmp_tgt_q;
                end else if (br_q) begin
                    pc_add = 1'b1;
                    pc_d   = br_off_q;
                end else begin
                    pc_increment = 1'b1;
                end
                state_d = halt_q ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (resume && !halt) begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                pc_replace = 1'b1;
                pc_d       = TRAP_VECTOR;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
            cnt_q      <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            jmp_q      <= 1'b0;
            br_q       <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if ((state_q == S_FETCH) && !ack_take && !timeout) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= '0;
            end
            if (ack_take) begin
                ir_q       <= mem_rdata;
                ir_valid_q <= 1'b1;
            end else if (exec_take) begin
                ir_valid_q <= 1'b0;
            end
            if (timeout) begin
                fault_q <= 1'b1;
            end
            if (exec_take) begin
                jmp_q  <= jmp_valid;
                br_q   <= br_taken;
                halt_q <= halt;
            end
        end
    end

    // Operands are qualified by the latched flags, so they need no reset.
    always_ff @(posedge clk) begin
        if (exec_take) begin
            jmp_tgt_q <= jmp_target;
            br_off_q  <= br_offset;
        end
    end

    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven instructions plus directed
// timeout, halt and reset-abort sequences, with a strobe scoreboard and PC model.
module tb_pc_sequencer;

    localparam logic [15:0] TV = 16'hFFF0;
    localparam int          FT = 8;

    localparam logic [2:0] S_REP = 3'b100;
    localparam logic [2:0] S_INC = 3'b010;
    localparam logic [2:0] S_ADD = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] ir;
    logic        ir_valid;
    logic        exec_done = 1'b0;
    logic        jmp_valid = 1'b0;
    logic [15:0] jmp_target = 16'h0;
    logic        br_taken = 1'b0;
    logic [15:0] br_offset = 16'h0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        pc_replace;
    logic        pc_increment;
    logic        pc_add;
    logic [15:0] pc_d;
    logic        fault;

    pc_sequencer #(.TRAP_VECTOR(TV), .FETCH_TIMEOUT(FT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .exec_done   (exec_done),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .halt        (halt),
        .resume      (resume),
        .pc_replace  (pc_replace),
        .pc_increment(pc_increment),
        .pc_add      (pc_add),
        .pc_d        (pc_d),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          fd;
        int          ew;
        logic [15:0] word;
        logic        jv;
        logic [15:0] jt;
        logic        bt;
        logic [15:0] bo;
        logic        hlt;
        logic [2:0]  es;
        logic [15:0] ed;
        logic        ef;
    } vec_t;

    typedef struct {
        logic [2:0]  s;
        logic [15:0] d;
        logic [15:0] pc;
    } sb_t;

    sb_t         sbq[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_pc = 16'h0;
    logic [15:0] mod_pc = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] s, input logic [15:0] d);
        sb_t e;
        if (s == S_REP)      exp_pc = d;
        else if (s == S_ADD) exp_pc = exp_pc + d;
        else                 exp_pc = exp_pc + 16'd1;
        e.s  = s;
        e.d  = d;
        e.pc = exp_pc;
        sbq.push_back(e);
    endtask

    // Strobe monitor: every strobe must match the next scoreboard entry; idle pc_d is 0.
    always @(negedge clk) begin
        logic [2:0] s;
        sb_t        e;
        s = {pc_replace, pc_increment, pc_add};
        if (s == 3'b000) begin
            check("pc_d_idle", pc_d, 0);
        end else begin
            check("strobe_onehot", $countones(s), 1);
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got %b pc_d=%h, none expected at %0t", s, pc_d, $time);
            end else begin
                e = sbq.pop_front();
                check("strobe", s, e.s);
                check("pc_d", pc_d, e.d);
                if (s[2])      mod_pc = pc_d;
                else if (s[0]) mod_pc = mod_pc + pc_d;
                else           mod_pc = mod_pc + 16'd1;
                check("pc_model", mod_pc, e.pc);
            end
        end
    end

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(S_REP, 16'h0000);
        @(negedge clk);
        check("rel_req", mem_req, 0);
        cyc();
        @(negedge clk);
        check("rel_req2", mem_req, 0);
        check("rel_ir", ir, 0);
        check("rel_irv", ir_valid, 0);
        check("rel_fault", fault, 0);
        cyc();
    endtask

    task automatic fetch_word(input int fd, input logic [15:0] w);
        for (int i = 0; i < fd; i++) begin
            mem_ack    = 1'b0;
            mem_rdata  = 16'($urandom);
            exec_done  = 1'b1;
            jmp_valid  = 1'b1;
            jmp_target = 16'h0BAD;
            @(negedge clk);
            check("fetch_req", mem_req, 1);
            cyc();
        end
        exec_done = 1'b0;
        jmp_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = w;
        @(negedge clk);
        check("fetch_req_ack", mem_req, 1);
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
    endtask

    task automatic exec_insn(input vec_t v);
        fetch_word(v.fd, v.word);
        for (int i = 0; i < v.ew; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hDEAD;
            @(negedge clk);
            check("exec_ir", ir, v.word);
            check("exec_irv", ir_valid, 1);
            check("exec_req", mem_req, 0);
            check("exec_fault", fault, v.ef);
            cyc();
        end
        mem_ack    = 1'b0;
        exec_done  = 1'b1;
        jmp_valid  = v.jv;
        jmp_target = v.jt;
        br_taken   = v.bt;
        br_offset  = v.bo;
        halt       = v.hlt;
        push_exp(v.es, v.ed);
        @(negedge clk);
        check("done_ir", ir, v.word);
        check("done_irv", ir_valid, 1);
        check("done_fault", fault, v.ef);
        cyc();
        exec_done  = 1'b0;
        jmp_valid  = 1'b0;
        jmp_target = 16'h0;
        br_taken   = 1'b0;
        br_offset  = 16'h0;
        halt       = 1'b0;
        @(negedge clk);
        check("upd_irv", ir_valid, 0);
        check("upd_req", mem_req, 0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t v;

        //          fd ew word      jv  jt        bt  bo        hlt es     ed        ef
        vecs[0] = '{2, 1, 16'h1234, 0, 16'h0000, 0, 16'h0000, 0, S_INC, 16'h0000, 0};
        vecs[1] = '{0, 0, 16'h0001, 0, 16'h0000, 1, 16'hFFFE, 0, S_ADD, 16'hFFFE, 0};
        vecs[2] = '{1, 2, 16'h0002, 1, 16'h0040, 1, 16'h0003, 0, S_REP, 16'h0040, 0};
        vecs[3] = '{3, 0, 16'h0003, 0, 16'h0000, 1, 16'h0010, 0, S_ADD, 16'h0010, 0};
        vecs[4] = '{7, 1, 16'h0A5A, 0, 16'h0000, 0, 16'h0000, 0, S_INC, 16'h0000, 0};
        vecs[5] = '{0, 1, 16'h0005, 1, 16'h1000, 0, 16'h0000, 0, S_REP, 16'h1000, 0};
        vecs[6] = '{1, 0, 16'h0006, 0, 16'h0000, 1, 16'h8000, 0, S_ADD, 16'h8000, 0};
        vecs[7] = '{2, 1, 16'h0007, 0, 16'h5555, 0, 16'h1234, 0, S_INC, 16'h0000, 0};
        vecs[8] = '{1, 0, 16'h0008, 0, 16'h0000, 0, 16'h0000, 0, S_INC, 16'h0000, 1};

        repeat (3) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_strobes", {pc_replace, pc_increment, pc_add}, 0);
        check("rst_pc_d", pc_d, 0);
        check("rst_ir", ir, 0);
        check("rst_irv", ir_valid, 0);
        check("rst_fault", fault, 0);
        release_reset();

        for (int i = 0; i < 8; i++) exec_insn(vecs[i]);

        // Fetch timeout: trap vector, sticky fault, then fetching restarts.
        push_exp(S_REP, TV);
        for (int i = 0; i < FT; i++) begin
            mem_ack = 1'b0;
            @(negedge clk);
            check("to_req", mem_req, 1);
            check("to_fault", fault, 0);
            cyc();
        end
        @(negedge clk);
        check("trap_req", mem_req, 0);
        check("trap_fault", fault, 1);
        cyc();
        @(negedge clk);
        check("post_trap_req", mem_req, 1);
        check("fault_sticky", fault, 1);
        cyc();
        exec_insn(vecs[8]);

        // Halt, ignore resume while halt is high, then resume.
        v = '{0, 0, 16'h0009, 0, 16'h0000, 0, 16'h0000, 1, S_INC, 16'h0000, 1};
        exec_insn(v);
        for (int i = 0; i < 5; i++) begin
            resume    = (i == 2);
            halt      = (i == 2);
            exec_done = (i == 3);
            jmp_valid = (i == 3);
            mem_ack   = (i == 4);
            mem_rdata = 16'hBEEF;
            @(negedge clk);
            check("halt_req", mem_req, 0);
            check("halt_ir", ir, v.word);
            cyc();
        end
        resume = 1'b1; halt = 1'b0; exec_done = 1'b0; jmp_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("resume_cycle_req", mem_req, 0);
        cyc();
        resume = 1'b0;
        @(negedge clk);
        check("resume_req", mem_req, 1);
        cyc();

        // Reset pulse while halted.
        v = '{1, 0, 16'h000A, 0, 16'h0000, 0, 16'h0000, 1, S_INC, 16'h0000, 1};
        exec_insn(v);
        rst_n = 1'b0;
        #1;
        check("hrst_req", mem_req, 0);
        check("hrst_ir", ir, 0);
        check("hrst_irv", ir_valid, 0);
        check("hrst_fault", fault, 0);
        release_reset();

        // Reset mid-fetch, then a 7-cycle-late ack must not trap.
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b0;
            @(negedge clk);
            check("mf_req", mem_req, 1);
            cyc();
        end
        rst_n = 1'b0;
        #1;
        check("mf_abort_req", mem_req, 0);
        release_reset();
        v = '{7, 0, 16'h00C0, 0, 16'h0000, 0, 16'h0000, 0, S_INC, 16'h0000, 0};
        exec_insn(v);

        // Reset mid-UPDATE: the jump strobe is withdrawn before it is sampled.
        fetch_word(1, 16'h7777);
        exec_done = 1'b1; jmp_valid = 1'b1; jmp_target = 16'h4444;
        @(negedge clk);
        check("mu_irv", ir_valid, 1);
        cyc();
        exec_done = 1'b0; jmp_valid = 1'b0;
        check("mu_update_replace", pc_replace, 1);
        check("mu_update_pc_d", pc_d, 16'h4444);
        #1;
        rst_n = 1'b0;
        #1;
        check("mu_abort_strobes", {pc_replace, pc_increment, pc_add}, 0);
        check("mu_abort_pc_d", pc_d, 0);
        @(negedge clk);
        check("mu_abort_pc", mod_pc, exp_pc);
        release_reset();
        @(negedge clk);
        check("final_req", mem_req, 1);
        check("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
